bidirectional_shift_register: RTL and testbench
===============================================

Name: bidirectional_shift_register

Overview:
- Parameterised serial-in, parallel-out shift register; the shift direction is selected every cycle by `mode`.
- Serial bit `din` enters at the LSB (left shift) or the MSB (right shift); the full register is always visible on `dout`.
- Used as a generic serialiser/deserialiser primitive wherever a direction-selectable shift chain is needed.

Parameters:
- N, default 8, register width in bits. Legal range is N >= 2.

Ports:
- clock  input  1  rising-edge clock; the only clock of the block.
- rst  input  1  reset; synchronous, active-high.
- din  input  1  serial data bit shifted in on each active edge.
- mode  input  1  shift direction: 1 = shift left (toward MSB), 0 = shift right (toward LSB).
- dout  output  N  parallel register contents; driven directly from the register (registered output).
- Port declaration order is din, mode, clock, rst, dout, because instances connect positionally.

Behaviour:
- Clocking and reset:
  - One clock; all state updates on the rising edge of `clock`.
  - Reset is synchronous and active-high: rst=1 at a rising edge gives dout = 0 (all N bits).
  - rst has priority over `mode` and `din`.
  - No asynchronous path; asserting rst between edges does not change dout until the next edge.
- Shift left (rst=0, mode=1): dout_next = {dout[N-2:0], din}.
  - din enters bit 0; bit N-1 is discarded.
- Shift right (rst=0, mode=0): dout_next = {din, dout[N-1:1]}.
  - din enters bit N-1; bit 0 is discarded.
- Shifting occurs on every non-reset edge. There is no enable and no hold state.
- Latency:
  - din sampled at edge k appears in dout immediately after edge k (bit 0 or bit N-1).
  - A bit reaches the far end after N-1 further shifts in the same direction.
- Direction change takes effect on the very edge where the new mode is sampled. No pipeline; no flush.
- Reset mid-stream clears all bits in one edge. Shifting resumes on the next edge with rst=0.
- No X-handling logic: an unknown din or mode propagates into the register as ordinary data.
- dout is purely the register. No combinational path exists from din, mode or rst to dout.
- Discarded (shifted-out) bits are not exported.

Test Plan:
- Reset: drive rst=1 for one edge from unknown state -> dout = 00000000. Then hold rst=1 for 3 more edges with din=1, mode=1 -> dout stays 00000000.
- Left shift: from 0, apply mode=1 with din = 1,0,1,1 on 4 edges -> dout = 00000001, 00000010, 00000101, 00001011.
- Right shift after left: continue from 00001011 with mode=0 and din = 0,0,1,1 -> dout = 00000101, 00000010, 10000001, 11000000.
- Fill/overflow: from 0, mode=1, din=1 for 9 edges -> dout reaches 11111111 after the 8th edge and remains 11111111 after the 9th. Then mode=0, din=0 for 8 edges -> 00000000.
- Reset mid-operation: load 10110011, assert rst for one edge while mode=1, din=1 -> 00000000. Next edge with rst=0, mode=0, din=1 -> 10000000.
- Parameter check: N=4, from 0 with mode=1, din = 1,1,0,1 -> 0001, 0011, 0110, 1101. Then mode=0, din=0 -> 0110.

Source files
------------

// File: rtl/bidirectional_shift_register.sv
`default_nettype none
// ============================================================================
// Module      : bidirectional_shift_register
// Description : Serial-in, parallel-out shift register whose direction is
//               chosen every cycle. mode=1 shifts toward the MSB with din
//               entering bit 0; mode=0 shifts toward the LSB with din entering
//               bit N-1. The register drives dout directly.
// Revision    : 1.0 - initial release
// ============================================================================
module bidirectional_shift_register #(
    parameter int N = 8
) (
    input  logic         din,
    input  logic         mode,
    input  logic         clock,
    input  logic         rst,
    output logic [N-1:0] dout
);

    localparam logic c_SHIFT_LEFT = 1'b1;

    logic [N-1:0] r_shift;
    logic [N-1:0] w_shift_left;
    logic [N-1:0] w_shift_right;

    // Candidate next values for each direction; bits shifted out are dropped.
    assign w_shift_left  = {r_shift[N-2:0], din};
    assign w_shift_right = {din, r_shift[N-1:1]};

    // Register update: reset wins, otherwise shift every edge in the selected direction.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_shift <= '0;
        end else if (mode == c_SHIFT_LEFT) begin
            r_shift <= w_shift_left;
        end else begin
            r_shift <= w_shift_right;
        end
    end

    assign dout = r_shift;

endmodule
`default_nettype wire

// File: tb/tb_bidirectional_shift_register.sv
`default_nettype none
// ============================================================================
// Module      : tb_bidirectional_shift_register
// Description : Self-checking bench for bidirectional_shift_register. Drives an
//               N=8 and an N=4 instance with identical stimulus, compares both
//               against an arithmetic reference model, and checks the directed
//               sequences against literal expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bidirectional_shift_register;

    logic       clock;
    logic       rst;
    logic       din;
    logic       mode;
    logic [7:0] dout8;
    logic [3:0] dout4;

    int checks = 0;
    int errors = 0;

    // Reference state as plain integers.
    int m8 = 0;
    int m4 = 0;

    bidirectional_shift_register #(.N(8)) u_dut8 (
        .din   (din),
        .mode  (mode),
        .clock (clock),
        .rst   (rst),
        .dout  (dout8)
    );

    bidirectional_shift_register #(.N(4)) u_dut4 (
        .din   (din),
        .mode  (mode),
        .clock (clock),
        .rst   (rst),
        .dout  (dout4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Next model value: multiply/divide by two with the new bit added at the
    // entry end, then wrapped to the register width.
    function automatic int model_next(input int cur, input int width,
                                      input logic r, input logic m, input logic d);
        int span;
        span = 1 << width;
        if (r) return 0;
        if (m) return (cur * 2 + int'(d)) % span;
        return cur / 2 + (d ? span / 2 : 0);
    endfunction

    // One clock edge with the given inputs, then compare both instances to the model.
    task automatic step(input logic r, input logic m, input logic d);
        rst  = r;
        mode = m;
        din  = d;
        @(posedge clock);
        #1;
        m8 = model_next(m8, 8, r, m, d);
        m4 = model_next(m4, 4, r, m, d);
        check("model8", {24'd0, dout8}, m8);
        check("model4", {28'd0, dout4}, m4);
    endtask

    task automatic step8(input logic r, input logic m, input logic d, input logic [7:0] exp);
        step(r, m, d);
        check("dir8", {24'd0, dout8}, {24'd0, exp});
    endtask

    task automatic step4(input logic r, input logic m, input logic d, input logic [3:0] exp);
        step(r, m, d);
        check("dir4", {28'd0, dout4}, {28'd0, exp});
    endtask

    initial begin
        logic [7:0] load_pat;
        rst  = 1'b1;
        mode = 1'b0;
        din  = 1'b0;
        #1;

        // Reset from unknown state, then held reset ignores din/mode.
        step8(1, 0, 0, 8'h00);
        repeat (3) step8(1, 1, 1, 8'h00);

        // Left shift 1,0,1,1.
        step8(0, 1, 1, 8'h01);
        step8(0, 1, 0, 8'h02);
        step8(0, 1, 1, 8'h05);
        step8(0, 1, 1, 8'h0B);

        // Right shift 0,0,1,1 continuing from 0x0B.
        step8(0, 0, 0, 8'h05);
        step8(0, 0, 0, 8'h02);
        step8(0, 0, 1, 8'h81);
        step8(0, 0, 1, 8'hC0);

        // Fill to all ones and overflow, then drain right.
        step8(1, 0, 0, 8'h00);
        for (int i = 0; i < 9; i++) step(0, 1, 1);
        check("fill8", {24'd0, dout8}, 32'hFF);
        for (int i = 0; i < 8; i++) step(0, 0, 0);
        check("drain8", {24'd0, dout8}, 32'h00);

        // Load 10110011 MSB first, then mid-stream reset.
        load_pat = 8'b1011_0011;
        for (int i = 7; i >= 0; i--) step(0, 1, load_pat[i]);
        check("load8", {24'd0, dout8}, 32'hB3);
        rst  = 1'b1;
        mode = 1'b1;
        din  = 1'b1;
        #2;
        check("rst_async", {24'd0, dout8}, 32'hB3);
        step8(1, 1, 1, 8'h00);
        step8(0, 0, 1, 8'h80);

        // Width-4 instance: 1,1,0,1 left then one right shift of 0.
        step(1, 0, 0);
        step4(0, 1, 1, 4'h1);
        step4(0, 1, 1, 4'h3);
        step4(0, 1, 0, 4'h6);
        step4(0, 1, 1, 4'hD);
        step4(0, 0, 0, 4'h6);

        // Random direction, data and occasional reset.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
